// File: rtl/stream_demux5.sv
// stream_demux5
//   Registered 1-to-5 valid/ready stream demultiplexer. Each input beat is
//   routed by a one-hot select to port 0..3. Any select that is not exactly
//   one-hot goes to default port 4. Each port has a one-entry output register,
//   so a stalled port blocks only beats aimed at it. Beats accepted into
//   port 4 are counted in a saturating counter that can be cleared.
//
// Ports
//   clk        in   1          clock, all state on rising edge
//   reset_n    in   1          asynchronous active-low reset
//   in_valid   in   1          input beat present
//   in_ready   out  1          input beat accepted when in_valid & in_ready
//   in_data    in   WIDTH      input payload
//   in_sel     in   4          one-hot target select, non-one-hot -> port 4
//   out_valid  out  5          per-port valid, bit k = port k
//   out_ready  in   5          per-port downstream ready
//   out_data   out  5*WIDTH    port k payload = out_data[k*WIDTH +: WIDTH]
//   err_clr    in   1          synchronous clear of err_cnt (wins over increment)
//   err_cnt    out  CW         saturating count of beats accepted into port 4
module stream_demux5 #(
    parameter int WIDTH = 8,
    parameter int CW    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [3:0]         in_sel,
    output logic [4:0]         out_valid,
    input  logic [4:0]         out_ready,
    output logic [5*WIDTH-1:0] out_data,
    input  logic               err_clr,
    output logic [CW-1:0]      err_cnt
);

    logic [4:0]         tgt_oh;
    logic               accept;
    logic [4:0]         out_valid_d, out_valid_q;
    logic [5*WIDTH-1:0] out_data_d,  out_data_q;
    logic [CW-1:0]      err_cnt_d,   err_cnt_q;

    // Target decode: only the four exact one-hot codes reach ports 0..3.
    always_comb begin
        tgt_oh = 5'b10000;
        unique case (in_sel)
            4'b0001: tgt_oh = 5'b00001;
            4'b0010: tgt_oh = 5'b00010;
            4'b0100: tgt_oh = 5'b00100;
            4'b1000: tgt_oh = 5'b01000;
            default: tgt_oh = 5'b10000;
        endcase
    end

    // Target port can take a beat if empty or draining this cycle.
    assign in_ready = |(tgt_oh & (~out_valid_q | out_ready));
    assign accept   = in_valid & in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_cnt_d   = err_cnt_q;
        for (int unsigned k = 0; k < 5; k++) begin
            // Drain clears valid; a same-cycle load sets it again (no bubble).
            out_valid_d[k] = (out_valid_q[k] & ~out_ready[k]) | (accept & tgt_oh[k]);
            if (accept && tgt_oh[k]) begin
                out_data_d[k*WIDTH +: WIDTH] = in_data;
            end
        end
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (accept && tgt_oh[4] && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err_cnt   = err_cnt_q;

endmodule
